// File: rtl/vram_arbiter.sv
// Shares one 8-bit VRAM port between the chroni video fetch engine and the CPU.
// Video has fixed priority; define VRAM_ARB_STARVE_GUARD_EN to enable the CPU anti-starvation counter.
module vram_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int PAGE_W       = 8,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     sys_clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        vid_addr,
  input  logic [PAGE_W-1:0]        vid_page,
  input  logic                     vid_rd_req,
  output logic                     vid_rd_ack,
  output logic [7:0]               vid_data,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [PAGE_W-1:0]        cpu_page,
  input  logic [7:0]               cpu_wdata,
  input  logic                     cpu_we,
  input  logic                     cpu_req,
  output logic                     cpu_ack,
  output logic [7:0]               cpu_rdata,
  output logic [ADDR_W+PAGE_W-1:0] mem_addr,
  output logic [7:0]               mem_wdata,
  output logic                     mem_ce,
  output logic                     mem_we,
  input  logic [7:0]               mem_rdata,
  output logic [1:0]               owner
);

  localparam int MA_W  = ADDR_W + PAGE_W;
  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_VID  = 2'b01;
  localparam logic [1:0] OWN_CPU  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state_q;
  logic [LAT_W-1:0]  lat_q;
  logic [1:0]        owner_q;
  logic [MA_W-1:0]   mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              mem_ce_q;
  logic              mem_we_q;
  logic              vid_rd_ack_q;
  logic              cpu_ack_q;
  logic [7:0]        vid_data_q;
  logic [7:0]        cpu_rdata_q;

  logic              force_cpu;
  logic              grant_vid;
  logic              grant_cpu;

  // Arbitration is only meaningful in IDLE; video wins unless the guard forces the CPU.
  always_comb begin
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    if (state_q == S_IDLE) begin
      if (cpu_req && (!vid_rd_req || force_cpu)) begin
        grant_cpu = 1'b1;
      end else if (vid_rd_req) begin
        grant_vid = 1'b1;
      end
    end
  end

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [STV_W-1:0] starve_q;

  assign force_cpu = (starve_q == STV_W'(STARVE_LIMIT));

  // Counts video grants made while the CPU waits; a forced CPU grant clears it, so it never wraps.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (!cpu_req || grant_cpu) begin
        starve_q <= '0;
      end else if (grant_vid) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end
`else
  // STARVE_LIMIT only matters with the guard built in; this expression is constant false.
  assign force_cpu = (STARVE_LIMIT < 0);
`endif

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      lat_q        <= '0;
      owner_q      <= OWN_NONE;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_ce_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      vid_rd_ack_q <= 1'b0;
      cpu_ack_q    <= 1'b0;
      vid_data_q   <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      vid_rd_ack_q <= 1'b0;
      cpu_ack_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_vid) begin
            mem_addr_q  <= {vid_page, vid_addr};
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_ce_q    <= 1'b1;
            owner_q     <= OWN_VID;
            lat_q       <= LAT_W'(MEM_LATENCY - 1);
            state_q     <= S_ACCESS;
          end else if (grant_cpu) begin
            mem_addr_q  <= {cpu_page, cpu_addr};
            mem_wdata_q <= cpu_wdata;
            mem_we_q    <= cpu_we;
            mem_ce_q    <= 1'b1;
            owner_q     <= OWN_CPU;
            lat_q       <= LAT_W'(MEM_LATENCY - 1);
            state_q     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (lat_q == '0) begin
            // Last access cycle: read data is valid now, so capture it and raise the ack for DONE.
            mem_ce_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (owner_q == OWN_VID) begin
              vid_data_q   <= mem_rdata;
              vid_rd_ack_q <= 1'b1;
            end else begin
              if (!mem_we_q) begin
                cpu_rdata_q <= mem_rdata;
              end
              cpu_ack_q <= 1'b1;
            end
            state_q <= S_DONE;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        S_DONE: begin
          owner_q <= OWN_NONE;
          state_q <= S_IDLE;
        end
        default: begin
          owner_q  <= OWN_NONE;
          mem_ce_q <= 1'b0;
          mem_we_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign vid_rd_ack = vid_rd_ack_q;
  assign vid_data   = vid_data_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_ce     = mem_ce_q;
  assign mem_we     = mem_we_q;
  assign owner      = owner_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed and random transactions against a transaction-level model.
// Memory returns a hash of the address only on the last access cycle, so early or late capture is visible.
module tb_vram_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [12:0] vid_addr;
  logic [7:0]  vid_page;
  logic        vid_rd_req;
  logic        vid_rd_ack;
  logic [7:0]  vid_data;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_page;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_req;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [20:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ce;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic [1:0]  owner;

  int checks = 0;
  int errors = 0;
  int ce_cnt = 0;
  logic [7:0] exp_vid_data = 8'h00;
  logic [7:0] exp_cpu_rdata = 8'h00;

  vram_arbiter dut (
    .sys_clk    (clk),
    .reset_n    (reset_n),
    .vid_addr   (vid_addr),
    .vid_page   (vid_page),
    .vid_rd_req (vid_rd_req),
    .vid_rd_ack (vid_rd_ack),
    .vid_data   (vid_data),
    .cpu_addr   (cpu_addr),
    .cpu_page   (cpu_page),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_req    (cpu_req),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ce     (mem_ce),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .owner      (owner)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_fn(input logic [20:0] a);
    return a[7:0] ^ {3'b000, a[12:8]} ^ a[20:13] ^ 8'h44;
  endfunction

  // Memory: data valid only in the MEM_LATENCY-th consecutive enabled cycle.
  always @(posedge clk) ce_cnt <= mem_ce ? ce_cnt + 1 : 0;
  assign mem_rdata = (mem_ce && ce_cnt == L - 1) ? rd_fn(mem_addr) : 8'hEE;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Raise one or both requests together and serve them; expected order and ack cycles
  // come from the rules: video first, L+1 cycles each, one idle cycle in between.
  task automatic run_pair(input bit dv, input bit dc, input bit cwe,
                          input logic [7:0] vp, input logic [12:0] va,
                          input logic [7:0] cp, input logic [12:0] ca,
                          input logic [7:0] wd, input string tag);
    int vid_t, cpu_t, ce_cycles, exp_v, exp_c;
    bit vdrop, cdrop;
    @(posedge clk); #1;
    vid_page = vp; vid_addr = va; vid_rd_req = dv;
    cpu_page = cp; cpu_addr = ca; cpu_wdata = wd; cpu_we = cwe; cpu_req = dc;
    vid_t = 0; cpu_t = 0; ce_cycles = 0; vdrop = 0; cdrop = 0;
    for (int n = 1; n <= 24 && (vid_rd_req || cpu_req); n++) begin
      @(posedge clk); #1;
      if (vdrop) begin vid_rd_req = 1'b0; vdrop = 0; end
      if (cdrop) begin cpu_req = 1'b0; cdrop = 0; end
      check({tag, " dual_ack"}, {31'd0, vid_rd_ack & cpu_ack}, 32'd0);
      if (mem_ce) begin
        ce_cycles++;
        if (owner == 2'b01) begin
          check({tag, " vid_mem_addr"}, {11'd0, mem_addr}, {11'd0, vp, va});
          check({tag, " vid_mem_we"}, {31'd0, mem_we}, 32'd0);
          vid_addr = 13'($urandom);
          vid_page = 8'($urandom);
        end else begin
          check({tag, " ce_owner"}, {30'd0, owner}, 32'd2);
          check({tag, " cpu_mem_addr"}, {11'd0, mem_addr}, {11'd0, cp, ca});
          check({tag, " cpu_mem_we"}, {31'd0, mem_we}, {31'd0, cwe});
          if (cwe) check({tag, " cpu_mem_wdata"}, {24'd0, mem_wdata}, {24'd0, wd});
          cpu_addr = 13'($urandom);
          cpu_page = 8'($urandom);
          cpu_wdata = 8'($urandom);
          cpu_we = 1'($urandom);
        end
      end
      if (vid_rd_ack) begin
        vid_t = n;
        vdrop = 1;
        exp_vid_data = rd_fn({vp, va});
        check({tag, " vid_data"}, {24'd0, vid_data}, {24'd0, exp_vid_data});
        check({tag, " vid_ack_owner"}, {30'd0, owner}, 32'd1);
      end
      if (cpu_ack) begin
        cpu_t = n;
        cdrop = 1;
        if (!cwe) exp_cpu_rdata = rd_fn({cp, ca});
        check({tag, " cpu_rdata"}, {24'd0, cpu_rdata}, {24'd0, exp_cpu_rdata});
        check({tag, " cpu_ack_owner"}, {30'd0, owner}, 32'd2);
      end
    end
    vid_rd_req = 1'b0;
    cpu_req = 1'b0;
    if (dv && dc) begin
      exp_v = L + 1;
      exp_c = 2 * (L + 1) + 1;
    end else begin
      exp_v = dv ? L + 1 : 0;
      exp_c = dc ? L + 1 : 0;
    end
    check({tag, " vid_ack_cycle"}, 32'(vid_t), 32'(exp_v));
    check({tag, " cpu_ack_cycle"}, 32'(cpu_t), 32'(exp_c));
    check({tag, " ce_cycles"}, 32'(ce_cycles), 32'(L * (int'(dv) + int'(dc))));
    check({tag, " idle_owner"}, {30'd0, owner}, 32'd0);
    $display("txn %s: vid=%0d cpu=%0d we=%0d vid_ack@%0d cpu_ack@%0d", tag, dv, dc, cwe, vid_t, cpu_t);
  endtask

  initial begin
    int vcount, n, sel;
    bit cpu_seen;
    logic [7:0] sp;
    logic [12:0] sa;

    reset_n = 1'b0;
    vid_addr = '0; vid_page = '0; vid_rd_req = 1'b0;
    cpu_addr = '0; cpu_page = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst owner", {30'd0, owner}, 32'd0);
    check("rst mem_ce", {31'd0, mem_ce}, 32'd0);
    check("rst mem_we", {31'd0, mem_we}, 32'd0);
    check("rst mem_addr", {11'd0, mem_addr}, 32'd0);
    check("rst acks", {30'd0, vid_rd_ack, cpu_ack}, 32'd0);
    check("rst vid_data", {24'd0, vid_data}, 32'd0);
    check("rst cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
    $display("txn reset: outputs checked");
    @(posedge clk); #1;
    reset_n = 1'b1;

    run_pair(1, 0, 0, 8'h00, 13'h0401, 8'h00, 13'h0000, 8'h00, "vid_read");
    run_pair(0, 1, 1, 8'h00, 13'h0000, 8'h02, 13'h0010, 8'hA5, "cpu_write");
    run_pair(0, 1, 0, 8'h00, 13'h0000, 8'h02, 13'h0010, 8'h00, "cpu_read");
    run_pair(1, 0, 0, 8'hFF, 13'h1FFF, 8'h00, 13'h0000, 8'h00, "vid_max");
    run_pair(0, 1, 0, 8'h00, 13'h0000, 8'hFF, 13'h1FFF, 8'h00, "cpu_max");
    run_pair(1, 1, 1, 8'h10, 13'h0123, 8'h20, 13'h0456, 8'h3C, "collide_w");
    run_pair(1, 1, 0, 8'h11, 13'h0ABC, 8'h22, 13'h1DEF, 8'h00, "collide_r");

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(1, 3);
      run_pair(sel[0], sel[1], 1'($urandom), 8'($urandom), 13'($urandom),
               8'($urandom), 13'($urandom), 8'($urandom), "random");
    end

    // Starvation: video requests back to back while the CPU waits.
    @(posedge clk); #1;
    sp = 8'h5C; sa = 13'h0777;
    cpu_page = sp; cpu_addr = sa; cpu_we = 1'b0; cpu_req = 1'b1;
    vid_page = 8'h01; vid_addr = 13'h0001; vid_rd_req = 1'b1;
    vcount = 0; cpu_seen = 0; n = 0;
    while (n < 300 && !cpu_seen && vcount < 20) begin
      @(posedge clk); #1;
      n++;
      check("starve dual_ack", {31'd0, vid_rd_ack & cpu_ack}, 32'd0);
      if (vid_rd_ack) begin
        vcount++;
        vid_addr = 13'($urandom);
      end
      if (cpu_ack) cpu_seen = 1;
    end
`ifdef VRAM_ARB_STARVE_GUARD_EN
    check("starve cpu_granted", {31'd0, cpu_seen}, 32'd1);
    check("starve vid_acks_before_cpu", 32'(vcount), 32'd8);
    vid_rd_req = 1'b0;
`else
    check("starve cpu_never", {31'd0, cpu_seen}, 32'd0);
    check("starve vid_acks", 32'(vcount), 32'd20);
    vid_rd_req = 1'b0;
    for (int k = 0; k < 20 && !cpu_seen; k++) begin
      @(posedge clk); #1;
      if (cpu_ack) cpu_seen = 1;
    end
    check("starve cpu_after_release", {31'd0, cpu_seen}, 32'd1);
`endif
    exp_cpu_rdata = rd_fn({sp, sa});
    check("starve cpu_rdata", {24'd0, cpu_rdata}, {24'd0, exp_cpu_rdata});
    @(posedge clk); #1;
    cpu_req = 1'b0;
    $display("txn starve: video acks=%0d cpu granted=%0d", vcount, cpu_seen);

    // Reset in the middle of an access: everything drops at once and no ack follows.
    @(posedge clk); #1;
    vid_page = 8'h03; vid_addr = 13'h0030; vid_rd_req = 1'b1;
    @(posedge clk); #1;
    check("midrst in_access", {31'd0, mem_ce}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst mem_ce", {31'd0, mem_ce}, 32'd0);
    check("midrst owner", {30'd0, owner}, 32'd0);
    check("midrst acks", {30'd0, vid_rd_ack, cpu_ack}, 32'd0);
    vid_rd_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    cpu_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (vid_rd_ack || cpu_ack) cpu_seen = 1;
    end
    check("midrst no_ack_after", {31'd0, cpu_seen}, 32'd0);
    exp_vid_data = 8'h00;
    exp_cpu_rdata = 8'h00;
    check("midrst vid_data", {24'd0, vid_data}, 32'd0);
    $display("txn midreset: aborted access, no ack");
    run_pair(1, 0, 0, 8'h03, 13'h0030, 8'h00, 13'h0000, 8'h00, "rerequest");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
